pump_controller: RTL and testbench
==================================

PUMP_CONTROLLER -- requirements
Module: pump_controller

Interface
REQ-001 Parameter: CLK_HZ, default 50_000_000, system clock frequency used to derive a 1 ms tick.
REQ-002 Parameter: CAP_ML, default 20000, tank capacity in ml; the target is clamped to this value.
REQ-003 Parameter: MIN_RISE_ML, default 10, the volume increase that counts as pumping progress.
REQ-004 Parameter: STALL_MS, default 5000, maximum time without progress while pumping.
REQ-005 Parameter: MAX_RUN_MS, default 600000, absolute limit on one pumping run.
REQ-006 Parameter: SETTLE_MS, default 500, post-stop delay before done is declared.
REQ-007 clk  in  1  single system clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  request to begin a fill, sampled each cycle.
REQ-010 stop  in  1  abort request, sampled each cycle.
REQ-011 clear  in  1  fault acknowledge.
REQ-012 target_ml  in  32  requested final volume in ml, captured when start is accepted.
REQ-013 volume_ml  in  32  measured volume from the distance-to-ml conversion.
REQ-014 vol_valid  in  1  one-cycle strobe marking a new volume_ml sample.
REQ-015 pump_en  out  1  pump relay drive.
REQ-016 busy  out  1  high in PUMPING or SETTLE.
REQ-017 done  out  1  one-cycle pulse when a fill completes.
REQ-018 fault  out  1  high while in FAULT.
REQ-019 fault_code  out  2  0 none, 1 stall, 2 overrun, 3 no sensor data.
REQ-020 state  out  3  current state encoding, for the display.

Function
REQ-021 States: IDLE, PUMPING, SETTLE, DONE, FAULT; all outputs are registered.
REQ-022 Every vol_valid latches volume_ml into vol_q and sets has_sample, in all states.
REQ-023 Start is accepted only in IDLE; captured target is tgt = min(target_ml, CAP_ML).
REQ-024 Start with has_sample=0 goes to FAULT with code 3.
REQ-025 Start with vol_q >= tgt goes to DONE directly and pump_en never asserts.
REQ-026 Otherwise start goes to PUMPING; pump_en rises on the cycle after start is sampled, ref_ml=vol_q, and the stall and run timers clear.
REQ-027 In PUMPING, a vol_valid with volume_ml >= ref_ml+MIN_RISE_ML sets ref_ml=volume_ml and clears the stall timer.
REQ-028 In PUMPING, a vol_valid with volume_ml >= tgt goes to SETTLE with pump_en=0 and clears the settle timer.
REQ-029 Stall timer reaching STALL_MS ms gives FAULT code 1; run timer reaching MAX_RUN_MS ms gives FAULT code 2.
REQ-030 Same-cycle priority in PUMPING: stop > overrun > stall > target reached.
REQ-031 Stop in PUMPING or SETTLE returns to IDLE with pump_en=0 and no done pulse.
REQ-032 SETTLE waits SETTLE_MS ms, then enters DONE.
REQ-033 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-034 In FAULT, pump_en=0; fault and fault_code hold until clear=1, then the block returns to IDLE with fault_code=0; start is ignored in FAULT.
REQ-035 Timers count 1 ms ticks, saturate at their limits and never wrap; 32-bit volume compares are unsigned; the ref_ml+MIN_RISE_ML addition saturates at 2^32-1.

Reset
REQ-036 While rst_n=0: state=IDLE, and pump_en, busy, done, fault, fault_code, vol_q, has_sample, ref_ml, tgt and all timers are 0.
REQ-037 Reset asserted mid-fill drops pump_en asynchronously, with no wait for a clock edge.

Structure
REQ-038 State encodings, fault codes and the ms-tick divide constant belong in shared package fuel_pkg.
REQ-039 The 1 ms prescaler is sub-module ms_tick_gen, a one-cycle tick every CLK_HZ/1000 clocks; the controller instantiates it once.

Verification
REQ-040 Run the bench with CLK_HZ=1000 (tick every clock), STALL_MS=20, MAX_RUN_MS=100, SETTLE_MS=5.
REQ-041 Normal fill: vol 100, then start with target 500, then samples 150, 300, 500 -> pump_en 1 from start+1 until the 500 sample; done pulses 5 ms later; busy low afterwards.
REQ-042 Already full: vol 600, start with target 500 -> DONE next cycle, done=1 for one cycle, pump_en never 1.
REQ-043 Stall: vol 100, start with target 500, then samples stay at 105 -> FAULT code 1 after 20 ms; pump_en 0; clear returns to IDLE with code 0.
REQ-044 No data and clamp: start before any vol_valid -> FAULT code 3; after clear, vol 0 and start with target 30000 -> tgt=20000.
REQ-045 Priority and reset: stop and a 500 sample in the same cycle -> IDLE with no done; rst_n low mid-PUMPING -> pump_en 0 immediately and all outputs 0.

Source files
------------

// File: rtl/fuel_pkg.sv
// Shared definitions for the pump controller slice.
//   state_e  : controller state encoding (also driven out on the display port)
//   fault_e  : fault reason codes reported on fault_code
//   MS_PER_S / ms_tick_div : derive the clock divide for a 1 ms tick
package fuel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUMPING = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_STALL   = 2'd1,
        FC_OVERRUN = 2'd2,
        FC_NO_DATA = 2'd3
    } fault_e;

    localparam int unsigned MS_PER_S = 1000;

    // Clocks per 1 ms tick; never below 1 so very slow clocks tick every cycle.
    function automatic int unsigned ms_tick_div(input int unsigned clk_hz);
        return (clk_hz / MS_PER_S >= 1) ? (clk_hz / MS_PER_S) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms prescaler: emits a registered one-cycle tick every DIV clocks.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse, period DIV clocks (constantly high when DIV = 1)
module ms_tick_gen #(
    parameter int unsigned DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pump_controller.sv
// Tank fill controller: runs a pump relay until the measured volume reaches a
// captured target, with stall / overrun / missing-sensor supervision.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, stop, clear  : fill request, abort, fault acknowledge
//   target_ml           : requested final volume (clamped to CAP_ML on start)
//   volume_ml/vol_valid : measured volume and its one-cycle sample strobe
//   pump_en             : relay drive
//   busy, done, fault   : status (busy in PUMPING/SETTLE, done one-cycle pulse)
//   fault_code          : fault_e reason, 0 outside FAULT
//   state               : state_e encoding for the display
module pump_controller
    import fuel_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned CAP_ML      = 20000,
    parameter int unsigned MIN_RISE_ML = 10,
    parameter int unsigned STALL_MS    = 5000,
    parameter int unsigned MAX_RUN_MS  = 600000,
    parameter int unsigned SETTLE_MS   = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [31:0] target_ml,
    input  logic [31:0] volume_ml,
    input  logic        vol_valid,
    output logic        pump_en,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state
);

    localparam logic [31:0] CAP_L    = 32'(CAP_ML);
    localparam logic [31:0] RISE_L   = 32'(MIN_RISE_ML);
    localparam logic [31:0] STALL_L  = 32'(STALL_MS);
    localparam logic [31:0] RUN_L    = 32'(MAX_RUN_MS);
    localparam logic [31:0] SETTLE_L = 32'(SETTLE_MS);

    logic tick;

    ms_tick_gen #(
        .DIV (ms_tick_div(CLK_HZ))
    ) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    state_e      state_q, state_d;
    fault_e      fault_code_q, fault_code_d;
    logic        pump_en_q, pump_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        has_sample_q, has_sample_d;
    logic [31:0] vol_q, vol_d;
    logic [31:0] ref_q, ref_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] run_q, run_d;
    logic [31:0] settle_q, settle_d;

    logic [31:0] tgt_clamped;
    logic [32:0] rise_sum;
    logic [31:0] rise_lim;
    logic        progress;
    logic [31:0] stall_inc, run_inc, settle_inc;

    always_comb begin
        tgt_clamped = (target_ml > CAP_L) ? CAP_L : target_ml;

        // Progress threshold saturates so a reference near 2^32-1 cannot wrap.
        rise_sum = {1'b0, ref_q} + {1'b0, RISE_L};
        rise_lim = rise_sum[32] ? '1 : rise_sum[31:0];
        progress = vol_valid && (volume_ml >= rise_lim);

        // Saturating ms timers; limits are compared against the incremented
        // value so a fault fires on the tick that reaches the limit.
        stall_inc  = (tick && stall_q  < STALL_L)  ? stall_q  + 32'd1 : stall_q;
        run_inc    = (tick && run_q    < RUN_L)    ? run_q    + 32'd1 : run_q;
        settle_inc = (tick && settle_q < SETTLE_L) ? settle_q + 32'd1 : settle_q;

        state_d      = state_q;
        fault_code_d = fault_code_q;
        vol_d        = vol_q;
        has_sample_d = has_sample_q;
        ref_d        = ref_q;
        tgt_d        = tgt_q;
        stall_d      = stall_q;
        run_d        = run_q;
        settle_d     = settle_q;

        if (vol_valid) begin
            vol_d        = volume_ml;
            has_sample_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tgt_d = tgt_clamped;
                    if (!has_sample_q) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_NO_DATA;
                    end else if (vol_q >= tgt_clamped) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PUMPING;
                        ref_d   = vol_q;
                        stall_d = '0;
                        run_d   = '0;
                    end
                end
            end
            ST_PUMPING: begin
                run_d   = run_inc;
                stall_d = progress ? '0 : stall_inc;
                if (progress) begin
                    ref_d = volume_ml;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (run_inc >= RUN_L) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_OVERRUN;
                end else if (!progress && stall_inc >= STALL_L) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_STALL;
                end else if (vol_valid && volume_ml >= tgt_q) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_inc;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (settle_inc >= SETTLE_L) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_FAULT) begin
            fault_code_d = FC_NONE;
        end

        // Outputs are decoded from the next state so they register alongside it.
        pump_en_d = (state_d == ST_PUMPING);
        busy_d    = (state_d == ST_PUMPING) || (state_d == ST_SETTLE);
        done_d    = (state_d == ST_DONE);
        fault_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fault_code_q <= FC_NONE;
            pump_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            has_sample_q <= 1'b0;
            vol_q        <= '0;
            ref_q        <= '0;
            tgt_q        <= '0;
            stall_q      <= '0;
            run_q        <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            pump_en_q    <= pump_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            has_sample_q <= has_sample_d;
            vol_q        <= vol_d;
            ref_q        <= ref_d;
            tgt_q        <= tgt_d;
            stall_q      <= stall_d;
            run_q        <= run_d;
            settle_q     <= settle_d;
        end
    end

    assign pump_en    = pump_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pump_controller.sv
// Self-checking bench for pump_controller with a 1 ms tick on every clock.
module tb_pump_controller;
    import fuel_pkg::*;

    localparam int unsigned STALL  = 20;
    localparam int unsigned RUN    = 100;
    localparam int unsigned SETTLE = 5;
    localparam int unsigned CAP    = 20000;
    localparam int unsigned RISE   = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        vol_valid = 1'b0;
    logic [31:0] target_ml = '0;
    logic [31:0] volume_ml = '0;
    logic        pump_en, busy, done, fault;
    logic [1:0]  fault_code;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    pump_controller #(
        .CLK_HZ     (1000),
        .STALL_MS   (STALL),
        .MAX_RUN_MS (RUN),
        .SETTLE_MS  (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .target_ml  (target_ml),
        .volume_ml  (volume_ml),
        .vol_valid  (vol_valid),
        .pump_en    (pump_en),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Expected output bundle {state, pump_en, busy, done, fault, fault_code}
    // for a given controller mode.
    function automatic logic [8:0] outs(input state_e s, input logic [1:0] code);
        return {s, (s == ST_PUMPING), (s == ST_PUMPING || s == ST_SETTLE),
                (s == ST_DONE), (s == ST_FAULT), code};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [31:0] v);
        volume_ml = v;
        vol_valid = 1'b1;
        step();
        vol_valid = 1'b0;
    endtask

    task automatic begin_fill(input logic [31:0] tgt);
        target_ml = tgt;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
        end
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_normal_fill();
        logic [31:0] vals [2];
        vals[0] = 150;
        vals[1] = 300;
        sample(100);
        begin_fill(500);
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_PUMPING, 2'd0)) begin
            errors++;
            $display("FAIL fill_start got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_PUMPING, 2'd0));
        end
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(1, 10)) step();
            sample(vals[i]);
            checks++;
            if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_PUMPING, 2'd0)) begin
                errors++;
                $display("FAIL fill_progress got %b want %b",
                         {state, pump_en, busy, done, fault, fault_code}, outs(ST_PUMPING, 2'd0));
            end
        end
        repeat ($urandom_range(1, 10)) step();
        sample(500);
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_SETTLE, 2'd0)) begin
            errors++;
            $display("FAIL fill_reach got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_SETTLE, 2'd0));
        end
        for (int i = 1; i < int'(SETTLE); i++) begin
            step();
            checks++;
            if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_SETTLE, 2'd0)) begin
                errors++;
                $display("FAIL fill_settle got %b want %b",
                         {state, pump_en, busy, done, fault, fault_code}, outs(ST_SETTLE, 2'd0));
            end
        end
        step();
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_DONE, 2'd0)) begin
            errors++;
            $display("FAIL fill_done got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_DONE, 2'd0));
        end
        step();
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL fill_after got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
        end
    endtask

    task automatic test_already_full();
        logic [31:0] tgts [2];
        tgts[0] = 600;
        tgts[1] = 32'($urandom_range(1, 599));
        for (int i = 0; i < 2; i++) begin
            sample(600);
            begin_fill(tgts[i]);
            checks++;
            if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_DONE, 2'd0)) begin
                errors++;
                $display("FAIL full_done tgt=%0d got %b want %b", tgts[i],
                         {state, pump_en, busy, done, fault, fault_code}, outs(ST_DONE, 2'd0));
            end
            step();
            checks++;
            if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
                errors++;
                $display("FAIL full_idle got %b want %b",
                         {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
            end
        end
    endtask

    task automatic test_stall();
        sample(100);
        begin_fill(500);
        for (int k = 1; k <= int'(STALL); k++) begin
            if ($urandom_range(0, 2) == 0) begin
                volume_ml = 105;
                vol_valid = 1'b1;
            end
            step();
            vol_valid = 1'b0;
            if (k < int'(STALL)) begin
                checks++;
                if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_PUMPING, 2'd0)) begin
                    errors++;
                    $display("FAIL stall_wait k=%0d got %b want %b", k,
                             {state, pump_en, busy, done, fault, fault_code}, outs(ST_PUMPING, 2'd0));
                end
            end else begin
                checks++;
                if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_FAULT, 2'd1)) begin
                    errors++;
                    $display("FAIL stall_fault got %b want %b",
                             {state, pump_en, busy, done, fault, fault_code}, outs(ST_FAULT, 2'd1));
                end
            end
        end
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_FAULT, 2'd1)) begin
            errors++;
            $display("FAIL stall_hold got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_FAULT, 2'd1));
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL stall_clear got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
        end
    endtask

    task automatic test_overrun();
        logic [31:0] cur = 0;
        sample(0);
        begin_fill(20000);
        for (int k = 1; k <= int'(RUN); k++) begin
            if (k % 10 == 0) begin
                cur       = cur + 20;
                volume_ml = cur;
                vol_valid = 1'b1;
            end
            step();
            vol_valid = 1'b0;
            if (k == int'(RUN)) begin
                checks++;
                if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_FAULT, 2'd2)) begin
                    errors++;
                    $display("FAIL overrun_fault got %b want %b",
                             {state, pump_en, busy, done, fault, fault_code}, outs(ST_FAULT, 2'd2));
                end
            end else if (k % 25 == 0) begin
                checks++;
                if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_PUMPING, 2'd0)) begin
                    errors++;
                    $display("FAIL overrun_wait k=%0d got %b want %b", k,
                             {state, pump_en, busy, done, fault, fault_code}, outs(ST_PUMPING, 2'd0));
                end
            end
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_no_data_clamp();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        begin_fill(500);
        step();
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_FAULT, 2'd3)) begin
            errors++;
            $display("FAIL nodata_fault got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_FAULT, 2'd3));
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL nodata_clear got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
        end
        sample(0);
        begin_fill(30000);
        repeat (3) step();
        sample(19995);
        sample(19999);
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_PUMPING, 2'd0)) begin
            errors++;
            $display("FAIL clamp_below got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_PUMPING, 2'd0));
        end
        sample(CAP);
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_SETTLE, 2'd0)) begin
            errors++;
            $display("FAIL clamp_reach got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_SETTLE, 2'd0));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL settle_stop got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
        end
    endtask

    task automatic test_priority_reset();
        logic saw_done = 1'b0;
        sample(100);
        begin_fill(500);
        repeat (3) step();
        volume_ml = 500;
        vol_valid = 1'b1;
        stop      = 1'b1;
        step();
        vol_valid = 1'b0;
        stop      = 1'b0;
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL stop_priority got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
        end
        for (int i = 0; i < 8; i++) begin
            step();
            saw_done = saw_done | done;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_done got %b want 0", saw_done);
        end
        sample(100);
        begin_fill(500);
        repeat (2) step();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL async_reset got %b want %b",
                     {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
        end
        step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    // Random fills judged by elapsed-ms arithmetic: overrun at RUN ms after
    // start, stall STALL ms after the last qualifying rise, then target reach.
    task automatic test_random_fills();
        for (int n = 0; n < 10; n++) begin
            int unsigned v0, tgt_in, tgt, ref_v, cur, last, t;
            logic        send, do_stop, prog, finished;
            state_e      exp_s;
            logic [1:0]  exp_c;
            v0 = $urandom_range(0, 400);
            if ($urandom_range(0, 3) == 0)      tgt_in = $urandom_range(0, v0);
            else if ($urandom_range(0, 5) == 0) tgt_in = 30000;
            else                                tgt_in = v0 + $urandom_range(1, 600);
            tgt = (tgt_in > CAP) ? CAP : tgt_in;
            sample(v0);
            begin_fill(tgt_in);
            exp_s = (v0 >= tgt) ? ST_DONE : ST_PUMPING;
            checks++;
            if ({state, pump_en, busy, done, fault, fault_code} !== outs(exp_s, 2'd0)) begin
                errors++;
                $display("FAIL rand_start n=%0d got %b want %b", n,
                         {state, pump_en, busy, done, fault, fault_code}, outs(exp_s, 2'd0));
            end
            if (exp_s == ST_DONE) begin
                step();
                continue;
            end
            ref_v = v0; cur = v0; last = 0; t = 0; finished = 1'b0;
            while (!finished && t < 2 * RUN) begin
                t++;
                send    = ($urandom_range(0, 4) == 0);
                do_stop = ($urandom_range(0, 150) == 0);
                if (send) begin
                    cur       = cur + $urandom_range(0, 30);
                    volume_ml = cur;
                    vol_valid = 1'b1;
                end
                stop = do_stop;
                prog = send && (cur >= ref_v + RISE);
                step();
                vol_valid = 1'b0;
                stop      = 1'b0;
                exp_c     = 2'd0;
                finished  = 1'b1;
                if (do_stop)                               exp_s = ST_IDLE;
                else if (t >= RUN)                         begin exp_s = ST_FAULT; exp_c = 2'd2; end
                else if (!prog && (t - last) >= STALL)     begin exp_s = ST_FAULT; exp_c = 2'd1; end
                else if (send && cur >= tgt)               exp_s = ST_SETTLE;
                else begin
                    exp_s    = ST_PUMPING;
                    finished = 1'b0;
                end
                if (prog) begin
                    ref_v = cur;
                    last  = t;
                end
                checks++;
                if ({state, pump_en, busy, done, fault, fault_code} !== outs(exp_s, exp_c)) begin
                    errors++;
                    $display("FAIL rand_step n=%0d t=%0d got %b want %b", n, t,
                             {state, pump_en, busy, done, fault, fault_code}, outs(exp_s, exp_c));
                end
            end
            if (exp_s == ST_SETTLE) begin
                repeat (SETTLE) step();
                checks++;
                if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_DONE, 2'd0)) begin
                    errors++;
                    $display("FAIL rand_done n=%0d got %b want %b", n,
                             {state, pump_en, busy, done, fault, fault_code}, outs(ST_DONE, 2'd0));
                end
                step();
            end else if (exp_s == ST_FAULT) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
            end
            checks++;
            if ({state, pump_en, busy, done, fault, fault_code} !== outs(ST_IDLE, 2'd0)) begin
                errors++;
                $display("FAIL rand_end n=%0d got %b want %b", n,
                         {state, pump_en, busy, done, fault, fault_code}, outs(ST_IDLE, 2'd0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_fill();
        test_already_full();
        test_stall();
        test_overrun();
        test_no_data_clamp();
        test_priority_reset();
        test_random_fills();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
